// File: rtl/prog3_match_engine.sv
// prog3_match_engine: loads a 5-bit pattern from mem[32], scans mem[0..31]
// one byte per cycle and writes three match counts back to memory:
//   mem[33] = ctb  (windows inside a byte that equal the pattern)
//   mem[34] = cto  (bytes holding at least one matching window)
//   mem[35] = cts  (matches across the whole 256-bit string, including
//                   windows that straddle a byte boundary)
// Build option: define PROG3_CTS_EN to include the cts counter and its
// write-back cycle; without it the run ends after the cto write.
//
// Handshake: req is sampled only in IDLE or DONE; a high sample starts a run
// and clears done on that same edge. done is registered, rises when the
// last write-back has completed and stays high until the next accepted req.
// dbg_state mirrors the FSM state for checkers.
module prog3_match_engine (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  output logic       done,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_PAT = 3'd1,
    SCAN     = 3'd2,
    WR_CTB   = 3'd3,
    WR_CTO   = 3'd4,
    WR_CTS   = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t      state, state_next;
  logic [4:0]  pat;
  logic [4:0]  idx;
  logic [7:0]  prev_byte;
  logic [7:0]  ctb;
  logic [7:0]  cto;
`ifdef PROG3_CTS_EN
  logic [7:0]  cts;
`endif

  // {previous byte, current byte}: windows starting at bits 0..3 lie inside
  // the current byte, windows starting at bits 4..7 straddle the boundary.
  logic [15:0] pair;
  logic [3:0]  hit_in;
  logic [3:0]  hit_x;
  logic [2:0]  cnt_in;
  logic [2:0]  cnt_x;

  assign pair      = {prev_byte, mem_rd_data};
  assign dbg_state = state;

  // Window comparisons and per-byte hit counts for the byte being scanned
  always_comb begin
    hit_in = '0;
    hit_x  = '0;
    cnt_in = '0;
    cnt_x  = '0;
    for (int w = 0; w < 4; w++) begin
      hit_in[w] = (pair[w +: 5] == pat);
      // Byte 0 has no predecessor, so it contributes no straddling windows.
      hit_x[w]  = (pair[w + 4 +: 5] == pat) && (idx != 5'd0);
    end
    for (int w = 0; w < 4; w++) begin
      cnt_in = cnt_in + {2'b00, hit_in[w]};
      cnt_x  = cnt_x  + {2'b00, hit_x[w]};
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and memory-port decode
  always_comb begin
    state_next  = state;
    mem_addr    = 8'd0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'd0;
    case (state)
      IDLE, DONE: begin
        if (req) state_next = LOAD_PAT;
      end
      LOAD_PAT: begin
        mem_addr   = 8'd32;
        state_next = SCAN;
      end
      SCAN: begin
        mem_addr = {3'b000, idx};
        if (idx == 5'd31) state_next = WR_CTB;
      end
      WR_CTB: begin
        mem_addr    = 8'd33;
        mem_wr_en   = 1'b1;
        mem_wr_data = ctb;
        state_next  = WR_CTO;
      end
      WR_CTO: begin
        mem_addr    = 8'd34;
        mem_wr_en   = 1'b1;
        mem_wr_data = cto;
`ifdef PROG3_CTS_EN
        state_next  = WR_CTS;
`else
        state_next  = DONE;
`endif
      end
`ifdef PROG3_CTS_EN
      WR_CTS: begin
        mem_addr    = 8'd35;
        mem_wr_en   = 1'b1;
        mem_wr_data = cts;
        state_next  = DONE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Datapath: start-of-run clears, pattern latch, per-byte accumulation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat       <= '0;
      idx       <= '0;
      prev_byte <= '0;
      ctb       <= '0;
      cto       <= '0;
`ifdef PROG3_CTS_EN
      cts       <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (req) begin
            idx       <= '0;
            prev_byte <= '0;
            ctb       <= '0;
            cto       <= '0;
`ifdef PROG3_CTS_EN
            cts       <= '0;
`endif
          end
        end
        LOAD_PAT: begin
          pat <= mem_rd_data[7:3];
          idx <= '0;
        end
        SCAN: begin
          ctb       <= ctb + {5'd0, cnt_in};
          cto       <= cto + {7'd0, |hit_in};
`ifdef PROG3_CTS_EN
          cts       <= cts + {5'd0, cnt_in} + {5'd0, cnt_x};
`endif
          prev_byte <= mem_rd_data;
          idx       <= idx + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // done is high exactly while the FSM sits in DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done <= 1'b0;
    else        done <= (state_next == DONE);
  end

endmodule

// File: doc/prog3_match_engine.md
PROG3_MATCH_ENGINE -- requirements
Module: prog3_match_engine

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port req  input  1  start request from the initiator, sampled on rising clk.
REQ-004 SHALL have port done  output  1  completion acknowledge, registered.
REQ-005 SHALL have port mem_addr  output  8  data-memory byte address.
REQ-006 SHALL have port mem_rd_data  input  8  data-memory read data, combinational from mem_addr, same cycle.
REQ-007 SHALL have port mem_wr_en  output  1  data-memory write strobe; memory writes on rising clk when high.
REQ-008 SHALL have port mem_wr_data  output  8  data-memory write data.

Function
REQ-009 SHALL implement states IDLE, LOAD_PAT, SCAN, WR_CTB, WR_CTO, WR_CTS, DONE.
REQ-010 IDLE/DONE: req=1 at an edge SHALL move to LOAD_PAT and clear ctb, cto, cts, byte index and the previous-byte register; done SHALL drop at that same edge.
REQ-011 LOAD_PAT: mem_addr=32; the next edge SHALL latch pat = mem_rd_data[7:3] and enter SCAN at index 0.
REQ-012 SCAN: mem_addr=index (0..31), one byte per cycle; after index 31 is consumed, SHALL enter WR_CTB.
REQ-013 ctb SHALL count, per byte b, each of b[4:0], b[5:1], b[6:2], b[7:3] equal to pat (0..128).
REQ-014 cto SHALL count bytes with at least one of those four windows equal to pat (0..32).
REQ-015 cts SHALL count offsets i=0..251 where str[255-i -: 5]==pat, str = {mem[0],...,mem[31]}, mem[0] most significant; windows spanning byte boundaries SHALL be counted exactly once (0..252).
REQ-016 Counters SHALL be 8 bits; no saturation is needed because the maxima fit.
REQ-017 WR_CTB/WR_CTO/WR_CTS SHALL each assert mem_wr_en for exactly one cycle, with addr/data 33/ctb, 34/cto, 35/cts respectively, in that order.
REQ-018 After WR_CTS the engine SHALL enter DONE; done SHALL be high in DONE only and held until a new req.
REQ-019 Latency: done SHALL first read high 36 cycles after the edge that sampled req.
REQ-020 req SHALL be ignored in LOAD_PAT, SCAN and WR_* states.
REQ-021 mem_wr_en SHALL be 0 in every state other than WR_*.
REQ-022 mem_addr SHALL be 0 in IDLE/DONE.

Reset
REQ-023 reset=0 SHALL immediately force IDLE, done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, and all counters, pat and index to 0.
REQ-024 Reset mid-operation SHALL abort with no further memory writes; the next req SHALL start a full fresh run.

Configuration
REQ-025 Macro PROG3_CTS_EN defined: cts logic and WR_CTS are present (REQ-015, REQ-017, REQ-019 apply).
REQ-026 PROG3_CTS_EN undefined: no cts logic, WR_CTS is removed, address 35 is never written, WR_CTO goes directly to DONE, and latency is 35 cycles.

Verification
REQ-027 pat=10101 (mem[32]=0xA8), mem[0..31]=0x55 -> mem[33]=64, mem[34]=32, mem[35]=126; done at cycle 36.
REQ-028 pat=00000, all bytes 0x00 -> 128, 32, 252.
REQ-029 pat=11111, all bytes 0x00 -> 0, 0, 0.
REQ-030 pat=11111, mem[5]=0x07, mem[6]=0xC0, others 0x00 -> ctb=0, cto=0, cts=1 (cross-byte only).
REQ-031 Run 1: reset pulsed low during SCAN at index 10 -> no writes observed to 33..35. Run 2: req issued after reset -> correct results, done 36 cycles after req.
REQ-032 Extra req pulses during SCAN -> exactly one write to each of 33/34/35 and a single done rise; with PROG3_CTS_EN undefined -> no write to 35 and latency 35.
